fir_coef_loader: RTL
====================

# fir_coef_loader

Runtime coefficient writer for the accelerator's FIR filter. Accepts coefficients one at a time over a valid/ready stream into a shadow bank. On an explicit commit it transfers the whole bank to the active tap outputs that feed the filter, so the filter never sees a partially updated coefficient set. It replaces the load-at-elaboration tap image, and its single-cycle `o_tap_wr` strobe drives the filter's tap-write input.

## Interface
- `NTAPS`, 5, number of filter taps (≥2)
- `TW`, 12, coefficient width in bits
- `i_clk`  in  1  sole clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_coef_valid`  in  1  coefficient on `i_coef` is valid
- `i_coef`  in  TW  coefficient value, two's complement, passed through unmodified
- `o_coef_ready`  out  1  loader accepts a coefficient this cycle
- `i_commit`  in  1  request transfer of shadow bank to active bank
- `i_abort`  in  1  discard the partial load and return to IDLE
- `o_taps`  out  NTAPS*TW  active coefficients; tap i at bits [i*TW +: TW]
- `o_tap_wr`  out  1  one-cycle strobe, high in the cycle `o_taps` first shows a new set
- `o_count`  out  $clog2(NTAPS+1)  coefficients accepted in the current load
- `o_err`  out  1  sticky: commit requested before the bank was full

## Operation
- NLOAD = NTAPS. With `FIR_COEF_SYMMETRIC_EN` defined, NLOAD = (NTAPS+1)/2.
- Handshake: a transfer occurs when `i_coef_valid && o_coef_ready` at a rising edge. The first accepted coefficient goes to shadow[0], the next to shadow[1], and so on. `o_coef_ready` is combinational from state, never from `i_coef_valid`.
- States:
  - IDLE: `o_count`=0, ready=1. A transfer writes shadow[0] and moves to LOAD, or to FULL if NLOAD is 1.
  - LOAD: ready=1. Each transfer writes shadow[o_count] and increments `o_count`. The transfer that makes `o_count` equal NLOAD moves to FULL.
  - FULL: ready=0. `i_commit` moves to COMMIT.
  - COMMIT: lasts exactly one cycle, ready=0. On entry edge, active ← shadow and `o_tap_wr` ← 1. Next state is IDLE with `o_count` ← 0.
- `o_taps` holds its previous value until a commit. The filter keeps running on the old set throughout a load.
- A commit is honoured only when sampled in FULL. An `i_commit` sampled in IDLE or LOAD sets `o_err` and is otherwise ignored, including in the cycle that accepts the final coefficient. `i_commit` held high in FULL triggers one commit; further high cycles in COMMIT or IDLE set `o_err`.
- `i_abort` in any state except COMMIT: next state IDLE, `o_count` ← 0, `o_err` ← 0. Any same-cycle handshake is dropped and the active bank is unchanged. Abort wins over a simultaneous commit or transfer.
- `i_abort` during COMMIT: the commit completes, then the loader is in IDLE with `o_err` cleared.
- Reset while `i_reset` is high: state IDLE, `o_count`=0, `o_err`=0, `o_tap_wr`=0, `o_taps`=0, shadow=0, and `o_coef_ready` forced to 0.

## Timing
- Accept rate: one coefficient per cycle. A full load takes NLOAD cycles with `i_coef_valid` held high.
- Commit latency: from `i_commit` sampled in FULL, `o_taps` and `o_tap_wr` change at that same edge and are visible in the following cycle. `o_tap_wr` is high for exactly one cycle.
- Back-to-back loads: the first coefficient of the next load is accepted in the cycle after COMMIT.
- All outputs are registered except `o_coef_ready`.

## Configuration
- `FIR_COEF_SYMMETRIC_EN` defined:
  - Only NLOAD=(NTAPS+1)/2 coefficients are loaded.
  - On commit, active[i] = active[NTAPS-1-i] = shadow[i] for i < NLOAD. The odd-NTAPS centre tap is loaded once.
  - The shadow bank is NLOAD entries deep.
- Undefined: all NTAPS coefficients are loaded individually, with no mirroring.

## Test plan
- Reset, then NTAPS=5: stream 1,2,3,4,5 back to back, commit. Expect `o_taps`={5,4,3,2,1} (tap4..tap0), one `o_tap_wr` pulse, `o_count` back to 0, `o_err`=0.
- Load 3 of 5 coefficients, then pulse `i_commit`. Expect `o_err`=1, `o_taps` unchanged, state stays LOAD. Loading 2 more and committing succeeds with `o_err` still 1.
- In FULL, assert `i_commit` and `i_abort` together. Expect no `o_tap_wr`, `o_taps` unchanged, IDLE, `o_count`=0, `o_err`=0.
- Hold `i_coef_valid` high through FULL. Expect `o_coef_ready`=0 and no shadow overwrite. After commit, the next value is captured as shadow[0] in the cycle after COMMIT.
- Assert `i_reset` mid-load (`o_count`=2) after a prior committed set. Expect `o_taps`=0, `o_count`=0, `o_coef_ready`=0 during reset, and 1 afterwards.
- With `FIR_COEF_SYMMETRIC_EN` defined and NTAPS=5: load 7,-3,9 and commit. Expect taps {7,-3,9,-3,7}, and FULL reached after 3 transfers.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Runtime FIR coefficient loader: streams taps into a shadow bank and commits them atomically.
// Optional build macro FIR_COEF_SYMMETRIC_EN loads half the taps and mirrors them on commit.
module fir_coef_loader #(
    parameter int unsigned NTAPS = 5,
    parameter int unsigned TW    = 12
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_coef_valid,
    input  logic [TW-1:0]                i_coef,
    output logic                         o_coef_ready,
    input  logic                         i_commit,
    input  logic                         i_abort,
    output logic [NTAPS*TW-1:0]          o_taps,
    output logic                         o_tap_wr,
    output logic [$clog2(NTAPS+1)-1:0]   o_count,
    output logic                         o_err
);

    localparam int unsigned CW = $clog2(NTAPS + 1);
`ifdef FIR_COEF_SYMMETRIC_EN
    localparam int unsigned NLOAD = (NTAPS + 1) / 2;
`else
    localparam int unsigned NLOAD = NTAPS;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;
    logic                tap_wr_q, tap_wr_d;
    logic [NTAPS*TW-1:0] taps_q, taps_d;
    logic [TW-1:0]       shadow_q [NLOAD];
    logic [TW-1:0]       shadow_d [NLOAD];
    logic [NTAPS*TW-1:0] taps_img;
    logic                xfer;

    // Tap image presented on commit; taps beyond NLOAD mirror the loaded half.
    for (genvar g = 0; g < NTAPS; g++) begin : g_map
        localparam int unsigned SRC = (g < NLOAD) ? g : (NTAPS - 1 - g);
        assign taps_img[g*TW +: TW] = shadow_q[SRC];
    end

    always_comb begin
        o_coef_ready = !i_reset && ((state_q == S_IDLE) || (state_q == S_LOAD));
    end

    assign xfer = o_coef_ready && i_coef_valid;

    // Next-state and register-update logic; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        tap_wr_d = 1'b0;
        taps_d   = taps_q;
        shadow_d = shadow_q;
        if (i_abort) begin
            state_d = S_IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (i_commit) begin
                        err_d = 1'b1;
                    end
                    if (xfer) begin
                        for (int i = 0; i < NLOAD; i++) begin
                            if (count_q == CW'(i)) begin
                                shadow_d[i] = i_coef;
                            end
                        end
                        count_d = count_q + CW'(1);
                        state_d = (count_q == CW'(NLOAD - 1)) ? S_FULL : S_LOAD;
                    end
                end
                S_FULL: begin
                    if (i_commit) begin
                        state_d  = S_COMMIT;
                        taps_d   = taps_img;
                        tap_wr_d = 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (i_commit) begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    count_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            err_q    <= 1'b0;
            tap_wr_q <= 1'b0;
            taps_q   <= '0;
            for (int i = 0; i < NLOAD; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            err_q    <= err_d;
            tap_wr_q <= tap_wr_d;
            taps_q   <= taps_d;
            shadow_q <= shadow_d;
        end
    end

    assign o_taps   = taps_q;
    assign o_tap_wr = tap_wr_q;
    assign o_count  = count_q;
    assign o_err    = err_q;

endmodule
